// File: rtl/master_port_pkg.sv
`default_nettype none
// ============================================================================
// Module   : master_port_pkg
// Brief    : Shared serial-bus package: port FSM state encoding, default
//            address/data widths and bit-counter sizing helper.
// Revision : 1.0 - initial release
// ============================================================================
package master_port_pkg;

    localparam int c_DEF_ADDR_WIDTH = 12;
    localparam int c_DEF_DATA_WIDTH = 8;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_ADDR  = 3'd2,
        S_WDATA = 3'd3,
        S_WAIT  = 3'd4,
        S_RDATA = 3'd5,
        S_SPLIT = 3'd6,
        S_DONE  = 3'd7
    } state_t;

    // Counter must hold the longest serial field length.
    function automatic int bit_cnt_width(input int a, input int d);
        return $clog2(((a > d) ? a : d) + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/master_port_piso_sipo.sv
`default_nettype none
// ============================================================================
// Module   : master_port_piso_sipo
// Brief    : Serial shift unit: address/write-data PISO, read-data SIPO and
//            shared bit counter, all LSB first.
// Revision : 1.0 - initial release
// ============================================================================
module master_port_piso_sipo
    import master_port_pkg::*;
#(
    parameter int ADDR_WIDTH = c_DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = c_DEF_DATA_WIDTH,
    parameter int CNT_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  tx_shift,
    input  logic                  tx_sel_data,
    input  logic                  rx_shift,
    input  logic                  rx_bit,
    input  logic                  cnt_clr,
    output logic                  tx_bit,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [CNT_WIDTH-1:0]  cnt
);

    logic [ADDR_WIDTH-1:0] r_addr_sr;
    logic [DATA_WIDTH-1:0] r_wdata_sr;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [CNT_WIDTH-1:0]  r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr_sr  <= '0;
            r_wdata_sr <= '0;
            r_rdata    <= '0;
            r_cnt      <= '0;
        end else begin
            if (load) begin
                r_addr_sr  <= addr;
                r_wdata_sr <= wdata;
            end else if (tx_shift) begin
                if (tx_sel_data) r_wdata_sr <= {1'b0, r_wdata_sr[DATA_WIDTH-1:1]};
                else             r_addr_sr  <= {1'b0, r_addr_sr[ADDR_WIDTH-1:1]};
            end
            // First received bit ends up in bit 0 after DATA_WIDTH shifts.
            if (rx_shift) r_rdata <= {rx_bit, r_rdata[DATA_WIDTH-1:1]};
            if (cnt_clr)                   r_cnt <= '0;
            else if (tx_shift || rx_shift) r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tx_bit = tx_sel_data ? r_wdata_sr[0] : r_addr_sr[0];
    assign rdata  = r_rdata;
    assign cnt    = r_cnt;

endmodule
`default_nettype wire

// File: rtl/master_port.sv
`default_nettype none
// ============================================================================
// Module   : master_port
// Brief    : Serial bus master port: arbitration, serial address/data
//            transfer, split handling. Option: MASTER_PORT_TIMEOUT_EN adds a
//            REQ/WAIT cycle timeout.
// Revision : 1.0 - initial release
// ============================================================================
module master_port
    import master_port_pkg::*;
#(
    parameter int ADDR_WIDTH = c_DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = c_DEF_DATA_WIDTH,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  dvalid,
    input  logic                  dmode,
    input  logic [ADDR_WIDTH-1:0] daddr,
    input  logic [DATA_WIDTH-1:0] dwdata,
    output logic                  dready,
    output logic                  dack,
    output logic [DATA_WIDTH-1:0] drdata,
    output logic                  derr,
    output logic                  breq,
    input  logic                  bgrant,
    input  logic                  msplit,
    output logic                  mout,
    output logic                  mvalid,
    output logic                  mmode,
    input  logic                  min,
    input  logic                  mvalid_in,
    input  logic                  sready
);

    localparam int c_CNT_W = bit_cnt_width(ADDR_WIDTH, DATA_WIDTH);

    state_t               r_state;
    state_t               w_next;
    logic                 r_mode;
    logic                 r_derr;
    logic                 w_err;
    logic                 w_load;
    logic                 w_tx_shift;
    logic                 w_rx_shift;
    logic                 w_cnt_clr;
    logic                 w_tx_bit;
    logic                 w_tmo;
    logic [c_CNT_W-1:0]   w_cnt;
    logic                 w_addr_last;
    logic                 w_data_last;

    master_port_piso_sipo #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .CNT_WIDTH  (c_CNT_W)
    ) u_shift (
        .clk         (clk),
        .rst         (rst),
        .load        (w_load),
        .addr        (daddr),
        .wdata       (dwdata),
        .tx_shift    (w_tx_shift),
        .tx_sel_data (r_state == S_WDATA),
        .rx_shift    (w_rx_shift),
        .rx_bit      (min),
        .cnt_clr     (w_cnt_clr),
        .tx_bit      (w_tx_bit),
        .rdata       (drdata),
        .cnt         (w_cnt)
    );

    assign w_addr_last = (w_cnt == c_CNT_W'(ADDR_WIDTH - 1));
    assign w_data_last = (w_cnt == c_CNT_W'(DATA_WIDTH - 1));
    assign w_cnt_clr   = (w_next != r_state);

`ifdef MASTER_PORT_TIMEOUT_EN
    localparam int c_TMO_W = $clog2(TIMEOUT + 1);
    logic [c_TMO_W-1:0] r_tmo;
    logic               w_tmo_state;

    assign w_tmo_state = (r_state == S_REQ) || (r_state == S_WAIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                    r_tmo <= '0;
        else if (w_next != r_state) r_tmo <= '0;
        else if (w_tmo_state)       r_tmo <= r_tmo + 1'b1;
    end

    assign w_tmo = w_tmo_state && (r_tmo == c_TMO_W'(TIMEOUT - 1));
`else
    assign w_tmo = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_mode  <= 1'b0;
            r_derr  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_derr  <= w_err;
            if (w_load) r_mode <= dmode;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_err      = 1'b0;
        w_load     = 1'b0;
        w_tx_shift = 1'b0;
        w_rx_shift = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (dvalid) begin
                    w_load = 1'b1;
                    w_next = S_REQ;
                end
            end
            S_REQ: begin
                if (bgrant) w_next = S_ADDR;
                else if (w_tmo) begin
                    w_err  = 1'b1;
                    w_next = S_IDLE;
                end
            end
            S_ADDR, S_WDATA: begin
                // Split is only honoured in WAIT/RDATA; here it merely masks the grant loss.
                if (!bgrant && !msplit) begin
                    w_err  = 1'b1;
                    w_next = S_IDLE;
                end else begin
                    w_tx_shift = 1'b1;
                    if (r_state == S_ADDR && w_addr_last)
                        w_next = r_mode ? S_WDATA : S_WAIT;
                    else if (r_state == S_WDATA && w_data_last)
                        w_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (msplit) w_next = S_SPLIT;
                else if (!bgrant) begin
                    w_err  = 1'b1;
                    w_next = S_IDLE;
                end else if (sready) w_next = r_mode ? S_DONE : S_RDATA;
                else if (w_tmo) begin
                    w_err  = 1'b1;
                    w_next = S_IDLE;
                end
            end
            S_RDATA: begin
                if (msplit) w_next = S_SPLIT;
                else if (!bgrant) begin
                    w_err  = 1'b1;
                    w_next = S_IDLE;
                end else if (mvalid_in) begin
                    w_rx_shift = 1'b1;
                    if (w_data_last) w_next = S_DONE;
                end
            end
            S_SPLIT: begin
                if (!msplit && bgrant) w_next = S_RDATA;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    assign dready = (r_state == S_IDLE);
    assign dack   = (r_state == S_DONE);
    assign derr   = r_derr;
    assign breq   = (r_state != S_IDLE) && (r_state != S_DONE);
    assign mvalid = (r_state == S_ADDR) || (r_state == S_WDATA);
    assign mout   = mvalid & w_tx_bit;
    assign mmode  = breq & r_mode;

endmodule
`default_nettype wire

// File: tb/tb_master_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_master_port
// Brief    : Scoreboard bench for master_port: directed transfers with
//            expected serial bits, acks and errors queued at stimulus time.
// Revision : 1.0 - initial release
// ============================================================================
module tb_master_port;

    localparam int c_AW = 12;
    localparam int c_DW = 8;
    localparam int K_BIT = 0;
    localparam int K_ACK = 1;
    localparam int K_ERR = 2;

    typedef struct {
        int         kind;
        logic [7:0] val;
        bit         chk;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            dvalid = 1'b0, dmode = 1'b0;
    logic [c_AW-1:0] daddr = '0;
    logic [c_DW-1:0] dwdata = '0;
    logic            dready, dack, derr, breq, mout, mvalid, mmode;
    logic [c_DW-1:0] drdata;
    logic            bgrant = 1'b0, msplit = 1'b0, min = 1'b0;
    logic            mvalid_in = 1'b0, sready = 1'b0;

    exp_t q[$];
    int   n_checks = 0;
    int   n_err    = 0;

    master_port #(.ADDR_WIDTH(c_AW), .DATA_WIDTH(c_DW), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .dvalid(dvalid), .dmode(dmode), .daddr(daddr),
        .dwdata(dwdata), .dready(dready), .dack(dack), .drdata(drdata),
        .derr(derr), .breq(breq), .bgrant(bgrant), .msplit(msplit),
        .mout(mout), .mvalid(mvalid), .mmode(mmode), .min(min),
        .mvalid_in(mvalid_in), .sready(sready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_bits(input logic [31:0] v, input int n);
        for (int i = 0; i < n; i++) q.push_back('{K_BIT, {7'd0, v[i]}, 1'b1});
    endtask

    task automatic push_ack(input logic [7:0] v, input bit chk);
        q.push_back('{K_ACK, v, chk});
    endtask

    task automatic push_err();
        q.push_back('{K_ERR, 8'd0, 1'b0});
    endtask

    task automatic issue(input logic mode, input logic [c_AW-1:0] a, input logic [c_DW-1:0] d);
        dvalid = 1'b1; dmode = mode; daddr = a; dwdata = d;
        tick();
        dvalid = 1'b0; daddr = '0; dwdata = '0;
    endtask

    // Drive serial read bits, with idle mvalid_in gaps ahead of some bits.
    task automatic send_bits(input logic [7:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            repeat (i % 3) tick();
            min = v[i]; mvalid_in = 1'b1;
            tick();
            min = 1'b0; mvalid_in = 1'b0;
        end
    endtask

    task automatic wait_resp(input string name, input int bound);
        int k;
        for (k = 0; k < bound; k++) begin
            @(negedge clk);
            if (dack || derr) break;
        end
        if (k == bound) check({name, "_resp_timeout"}, 0, 1);
    endtask

    task automatic wait_mvalid_end(input string name, input int bound);
        int  k;
        bit  seen = 1'b0;
        for (k = 0; k < bound; k++) begin
            @(negedge clk);
            if (mvalid) seen = 1'b1;
            else if (seen) break;
        end
        if (k == bound) check({name, "_mvalid_timeout"}, 0, 1);
    endtask

    task automatic wait_bits(input string name, input int n, input int bound);
        int k;
        int cnt = 0;
        for (k = 0; k < bound && cnt < n; k++) begin
            @(negedge clk);
            if (mvalid) cnt++;
        end
        if (cnt < n) check({name, "_bits_timeout"}, 0, 1);
    endtask

    // Monitor: every DUT output event consumes one scoreboard entry.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (mvalid) begin
                if (q.size() == 0) check("unexpected_serial_bit", 1, 0);
                else begin
                    e = q.pop_front();
                    check("serial_kind", e.kind, K_BIT);
                    check("serial_bit", {31'd0, mout}, {31'd0, e.val[0]});
                end
            end
            if (dack) begin
                check("dack_derr_exclusive", {31'd0, derr}, 0);
                if (q.size() == 0) check("unexpected_dack", 1, 0);
                else begin
                    e = q.pop_front();
                    check("dack_kind", e.kind, K_ACK);
                    if (e.chk) check("drdata", {24'd0, drdata}, {24'd0, e.val});
                end
            end else if (derr) begin
                if (q.size() == 0) check("unexpected_derr", 1, 0);
                else begin
                    e = q.pop_front();
                    check("derr_kind", e.kind, K_ERR);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        tick(); tick();
        @(negedge clk);
        check("rst_dready", {31'd0, dready}, 1);
        check("rst_breq",   {31'd0, breq}, 0);
        check("rst_mvalid", {31'd0, mvalid}, 0);
        check("rst_mout",   {31'd0, mout}, 0);
        check("rst_dack",   {31'd0, dack}, 0);
        check("rst_derr",   {31'd0, derr}, 0);
        check("rst_drdata", {24'd0, drdata}, 0);
        tick();
        rst = 1'b0;
        tick();

        // Write 0xA5 to 0x123, grant one cycle after breq.
        sready = 1'b1;
        push_bits(32'h123, 12); push_bits(32'hA5, 8); push_ack(8'h00, 1'b0);
        issue(1'b1, 12'h123, 8'hA5);
        @(negedge clk);
        check("wr_req_breq",   {31'd0, breq}, 1);
        check("wr_req_dready", {31'd0, dready}, 0);
        check("wr_req_mmode",  {31'd0, mmode}, 1);
        tick();
        bgrant = 1'b1;
        wait_resp("wr", 60);
        check("wr_done_breq", {31'd0, breq}, 0);
        tick();
        check("wr_idle_dready", {31'd0, dready}, 1);

        // Read 0x3C from 0x045 with mvalid_in gaps.
        push_bits(32'h045, 12); push_ack(8'h3C, 1'b1);
        issue(1'b0, 12'h045, 8'h00);
        @(negedge clk);
        check("rd_mmode", {31'd0, mmode}, 0);
        wait_mvalid_end("rd", 40);
        tick();
        send_bits(8'h3C, 8);
        wait_resp("rd", 20);
        tick();

        // Read with a split after 3 bits; 8 fresh bits of 0x96 afterwards.
        push_bits(32'h0F0, 12); push_ack(8'h96, 1'b1);
        issue(1'b0, 12'h0F0, 8'h00);
        wait_mvalid_end("split", 40);
        tick();
        send_bits(8'h07, 3);
        msplit = 1'b1; bgrant = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("split_breq", {31'd0, breq}, 1);
            tick();
        end
        msplit = 1'b0; bgrant = 1'b1;
        tick();
        send_bits(8'h96, 8);
        wait_resp("split", 20);
        tick();

        // Grant lost in the 4th write-data bit.
        push_bits(32'h001, 12); push_bits(32'hFF, 4); push_err();
        issue(1'b1, 12'h001, 8'hFF);
        wait_bits("gl", 15, 60);
        tick();
        bgrant = 1'b0;
        tick();
        @(negedge clk);
        check("gl_derr",   {31'd0, derr}, 1);
        check("gl_breq",   {31'd0, breq}, 0);
        check("gl_dready", {31'd0, dready}, 1);
        tick();
        @(negedge clk);
        check("gl_derr_pulse", {31'd0, derr}, 0);
        tick();

        // Asynchronous reset in the middle of ADDR.
        bgrant = 1'b1;
        push_bits(32'h3AB, 5);
        issue(1'b1, 12'h3AB, 8'h11);
        wait_bits("ar", 5, 40);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("ar_breq",   {31'd0, breq}, 0);
        check("ar_mvalid", {31'd0, mvalid}, 0);
        check("ar_mout",   {31'd0, mout}, 0);
        check("ar_dack",   {31'd0, dack}, 0);
        check("ar_derr",   {31'd0, derr}, 0);
        check("ar_dready", {31'd0, dready}, 1);
        check("ar_drdata", {24'd0, drdata}, 0);
        tick(); tick();
        rst = 1'b0;
        repeat (20) tick();
        bgrant = 1'b0;

`ifdef MASTER_PORT_TIMEOUT_EN
        // No grant: derr 16 cycles after REQ entry.
        begin
            int k;
            push_err();
            issue(1'b0, 12'h010, 8'h00);
            for (k = 0; k < 40; k++) begin
                @(negedge clk);
                if (derr) break;
            end
            check("timeout_cycles", k, 16);
            tick();
            check("timeout_idle", {31'd0, dready}, 1);
        end
`else
        // No grant: REQ waits indefinitely.
        issue(1'b0, 12'h010, 8'h00);
        repeat (40) tick();
        @(negedge clk);
        check("noto_breq",   {31'd0, breq}, 1);
        check("noto_dready", {31'd0, dready}, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
`endif

        repeat (3) tick();
        check("scoreboard_empty", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
